uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 61, meaning i_Clock cycles per bit time; the legal range SHALL be 4..255.
REQ-002 The module SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The module SHALL have port o_Rx_DV, output, 1 bit: one-cycle pulse marking a valid received byte.
REQ-006 The module SHALL have port o_Rx_Byte, output, 8 bits: the last valid byte, held until the next valid byte.
REQ-007 The module SHALL have port o_Rx_Active, output, 1 bit: high from start-bit detection until the frame ends or is rejected.
REQ-008 The module SHALL have port o_Rx_Err, output, 1 bit: one-cycle pulse on a framing error, or on a parity error when REQ-025 applies.

Function
REQ-009 The frame format SHALL be 1 start bit (0), 8 data bits LSB first, an optional parity bit (REQ-025), and 1 stop bit (1).
REQ-010 i_Rx_Serial SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rx_s).
REQ-011 The states SHALL be IDLE, START, DATA, PARITY, STOP, CLEANUP and WAIT_HIGH; the encoding SHALL be 3 bits, and undefined codes SHALL go to IDLE.
REQ-012 IDLE: the bit counter and clock counter SHALL be held at 0; rx_s==0 SHALL move to START and set o_Rx_Active the next cycle.
REQ-013 START: the clock counter SHALL count to (CLKS_PER_BIT-1)/2 (integer division); then rx_s==0 SHALL clear the counter and go to DATA, while rx_s==1 SHALL reject the glitch, go to IDLE, clear o_Rx_Active, and pulse neither output.
REQ-014 DATA: the module SHALL count CLKS_PER_BIT-1 clocks, then sample rx_s into internal shift bit [index]; after bit 7 it SHALL go to STOP (or PARITY), otherwise index+1.
REQ-015 STOP: the module SHALL count CLKS_PER_BIT-1 clocks, then sample; rx_s==1 SHALL load o_Rx_Byte, pulse o_Rx_DV for one cycle and go to CLEANUP.
REQ-016 STOP with rx_s==0 SHALL pulse o_Rx_Err for one cycle, leave o_Rx_Byte unchanged, not assert o_Rx_DV, and go to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL stay until rx_s==1 (a break condition does not retrigger), then go to IDLE.
REQ-018 CLEANUP SHALL last exactly one cycle, clear o_Rx_Active, and go to IDLE.
REQ-019 o_Rx_DV and o_Rx_Err SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-020 A start bit whose falling edge arrives during CLEANUP SHALL be detected from IDLE with at most 1 cycle of extra latency; back-to-back frames with one stop bit SHALL all be received.
REQ-021 Latency from the input falling edge to o_Rx_DV SHALL be 2 + 1 + (CLKS_PER_BIT-1)/2 + 1 + 9*CLKS_PER_BIT (+CLKS_PER_BIT with parity) cycles, +/-1.

Reset
REQ-022 While i_Reset is high at a clock edge, the state SHALL be IDLE; o_Rx_DV=0, o_Rx_Err=0, o_Rx_Active=0, o_Rx_Byte=8'h00, the counters SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-023 A reset mid-frame SHALL abandon the frame with no DV or Err pulse; reception SHALL resume at the next falling edge after reset is released.
REQ-024 Reset SHALL take priority over every state transition and output pulse in the same cycle.

Configuration
REQ-025 With UART_RX_PARITY_EN defined, the PARITY state SHALL sit between DATA and STOP, sampled after CLKS_PER_BIT-1 clocks, and expect even parity (XOR of 8 data bits and the parity bit = 0).
REQ-026 With UART_RX_PARITY_EN defined, a parity mismatch with a good stop bit SHALL pulse o_Rx_Err instead of o_Rx_DV, leave o_Rx_Byte unchanged, and go to CLEANUP.
REQ-027 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent, the frame SHALL be 10 bits, and o_Rx_Err SHALL flag framing errors only.

Verification (CLKS_PER_BIT=8)
REQ-028 Frame 0x3F, ideal timing -> exactly one o_Rx_DV pulse, o_Rx_Byte=0x3F, o_Rx_Err never high, o_Rx_Active low afterward.
REQ-029 2-clock low glitch on an idle line -> o_Rx_Active high for at most 6 cycles, no DV or Err pulse, o_Rx_Byte unchanged.
REQ-030 Valid 0x55, then frame 0xAA with stop bit 0 held low for 40 clocks -> one Err pulse, o_Rx_Byte stays 0x55, no restart until the line is high.
REQ-031 Back-to-back 0x00, 0xFF with no idle gap -> two DV pulses carrying 0x00 then 0xFF.
REQ-032 i_Reset pulsed during data bit 4 of 0x81, then a fresh 0x81 -> no pulse for the first frame, DV with 0x81 for the second.
REQ-033 UART_RX_PARITY_EN defined: 0xA5 with parity 0 -> DV, 0xA5; 0xA5 with parity 1 -> Err, no DV, o_Rx_Byte unchanged.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8-bit asynchronous serial receiver (start, 8 data LSB first,
//            optional even parity, 1 stop bit), oversampled by CLKS_PER_BIT.
//
// Parameters:
//   CLKS_PER_BIT  i_Clock cycles per bit time (legal 4..255, default 61)
//
// Ports:
//   i_Clock      single clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_Rx_Serial  asynchronous serial line, idle high
//   o_Rx_DV      one-cycle pulse: o_Rx_Byte holds a freshly received byte
//   o_Rx_Byte    last good byte, held until the next good byte
//   o_Rx_Active  high from start-bit detection until the frame ends/rejects
//   o_Rx_Err     one-cycle pulse on framing error (or parity error)
//
// Build option:
//   UART_RX_PARITY_EN  when defined, an even-parity bit sits between the
//                      last data bit and the stop bit.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 61
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Err
);

    localparam logic [7:0] LP_HALF = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LP_LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        CLEANUP   = 3'd5,
        WAIT_HIGH = 3'd6
    } state_t;

    logic       r_rx_meta, r_rx_s;
    state_t     r_state,   w_state_next;
    logic [7:0] r_clk_cnt, w_clk_cnt_next;
    logic [2:0] r_bit_idx, w_bit_idx_next;
    logic [7:0] r_shift,   w_shift_next;
    logic [7:0] r_byte,    w_byte_next;
    logic       r_dv,      w_dv_next;
    logic       r_err,     w_err_next;
    logic       r_active,  w_active_next;
`ifdef UART_RX_PARITY_EN
    logic       r_par_bit, w_par_bit_next;
    logic       w_par_ok;

    // Even parity: data bits and parity bit together hold an even number of 1s.
    assign w_par_ok = ~^{r_shift, r_par_bit};
`endif

    // Two-flop synchronizer; reset to the idle (high) line level so a reset
    // never looks like a falling edge.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours (r_rx_s gets old meta).
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_dv      <= 1'b0;
            r_err     <= 1'b0;
            r_active  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_byte    <= w_byte_next;
            r_dv      <= w_dv_next;
            r_err     <= w_err_next;
            r_active  <= w_active_next;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= w_par_bit_next;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path through
        // this block leaves a value unassigned, which would infer a latch.
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_byte_next    = r_byte;
        w_active_next  = r_active;
        w_dv_next      = 1'b0;
        w_err_next     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bit_next = r_par_bit;
`endif

        case (r_state)
            IDLE: begin
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
                if (!r_rx_s) begin
                    w_state_next  = START;
                    w_active_next = 1'b1;
                end
            end

            // Re-check the line half a bit in; a high level means it was a glitch.
            START: begin
                if (r_clk_cnt == LP_HALF) begin
                    w_clk_cnt_next = '0;
                    if (!r_rx_s) begin
                        w_state_next = DATA;
                    end else begin
                        w_state_next  = IDLE;
                        w_active_next = 1'b0;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 8'd1;
                end
            end

            DATA: begin
                if (r_clk_cnt == LP_LAST) begin
                    w_clk_cnt_next          = '0;
                    w_shift_next[r_bit_idx] = r_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_next   = PARITY;
`else
                        w_state_next   = STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 8'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_clk_cnt == LP_LAST) begin
                    w_clk_cnt_next = '0;
                    w_par_bit_next = r_rx_s;
                    w_state_next   = STOP;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 8'd1;
                end
            end
`endif

            STOP: begin
                if (r_clk_cnt == LP_LAST) begin
                    w_clk_cnt_next = '0;
                    if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (w_par_ok) begin
                            w_dv_next   = 1'b1;
                            w_byte_next = r_shift;
                        end else begin
                            w_err_next  = 1'b1;
                        end
`else
                        w_dv_next   = 1'b1;
                        w_byte_next = r_shift;
`endif
                        w_state_next = CLEANUP;
                    end else begin
                        // Framing error: the frame is rejected, so Active drops now
                        // and the line must return high before another start.
                        w_err_next    = 1'b1;
                        w_active_next = 1'b0;
                        w_state_next  = WAIT_HIGH;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 8'd1;
                end
            end

            CLEANUP: begin
                w_active_next = 1'b0;
                w_state_next  = IDLE;
            end

            WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next   = IDLE;
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
                w_active_next  = 1'b0;
            end
        endcase
    end

    assign o_Rx_DV     = r_dv;
    assign o_Rx_Err    = r_err;
    assign o_Rx_Active = r_active;
    assign o_Rx_Byte   = r_byte;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at CLKS_PER_BIT = 8.
// A table of frames is driven and checked (DV/Err pulse counts, held byte,
// Active level, DV latency), followed by hand-written corner sequences:
// start glitch, break after a bad stop bit, back-to-back frames, reset in
// mid-frame and, when UART_RX_PARITY_EN is defined, parity accept/reject.
// Inputs change on the falling clock edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int C = 8;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + 1 + (C - 1) / 2 + 1 + 10 * C;
`else
    localparam int LAT = 2 + 1 + (C - 1) / 2 + 1 + 9 * C;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       dv, err, active;
    logic [7:0] rx_byte;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (rx),
        .o_Rx_DV     (dv),
        .o_Rx_Byte   (rx_byte),
        .o_Rx_Active (active),
        .o_Rx_Err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: counts pulses and Active activity, remembers the last
    // two delivered bytes and flags illegal pulse combinations.
    int         dv_cnt = 0, err_cnt = 0, act_cyc = 0, act_rise = 0;
    int         viol_both = 0, viol_consec = 0, dv_cyc = 0;
    logic [7:0] last_b = 8'h00, prev_b = 8'h00;
    logic       prev_pulse = 1'b0, prev_act = 1'b0;

    always @(negedge clk) begin
        if (dv === 1'b1) begin
            dv_cnt <= dv_cnt + 1;
            dv_cyc <= cyc;
            prev_b <= last_b;
            last_b <= rx_byte;
        end
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (dv === 1'b1 && err === 1'b1) viol_both <= viol_both + 1;
        if ((dv === 1'b1 || err === 1'b1) && prev_pulse) viol_consec <= viol_consec + 1;
        prev_pulse <= (dv === 1'b1) || (err === 1'b1);
        if (active === 1'b1) act_cyc <= act_cyc + 1;
        if (active === 1'b1 && !prev_act) act_rise <= act_rise + 1;
        prev_act <= (active === 1'b1);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int start_cyc = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_len);
        start_cyc = cyc;
        drive_bit(1'b0, C);
        for (int i = 0; i < 8; i++) drive_bit(d[i], C);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip, C);
`endif
        drive_bit(stop_bit, stop_len);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_dv;
        int         exp_err;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0, e0, a0, r0;

        vecs[0] = '{8'h3F, 1'b1, 1, 0, 8'h3F};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[4] = '{8'h5A, 1'b0, 0, 1, 8'hA5};
        vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};
        vecs[6] = '{8'h01, 1'b0, 0, 1, 8'h81};
        vecs[7] = '{8'h7E, 1'b1, 1, 0, 8'h7E};

        // Reset state.
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset dv",     dv,      1'b0);
        check("reset err",    err,     1'b0);
        check("reset active", active,  1'b0);
        check("reset byte",   rx_byte, 8'h00);
        rst = 1'b0;
        idle(4);

        // Table of single frames.
        for (int v = 0; v < 8; v++) begin
            d0 = dv_cnt;
            e0 = err_cnt;
            send_frame(vecs[v].data, vecs[v].stop_bit, C);
            idle(2 * C);
            check($sformatf("vec%0d dv count", v),  dv_cnt - d0,  vecs[v].exp_dv);
            check($sformatf("vec%0d err count", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("vec%0d byte", v),      rx_byte,      vecs[v].exp_byte);
            check($sformatf("vec%0d active", v),    active,       1'b0);
            if (vecs[v].exp_dv == 1)
                check_win($sformatf("vec%0d latency", v), dv_cyc - start_cyc, LAT - 1, LAT + 1);
        end

        // Two-clock glitch on an idle line must be rejected.
        d0 = dv_cnt; e0 = err_cnt; a0 = act_cyc;
        drive_bit(1'b0, 2);
        idle(3 * C);
        check("glitch dv",   dv_cnt - d0,  0);
        check("glitch err",  err_cnt - e0, 0);
        check("glitch byte", rx_byte,      8'h7E);
        check_win("glitch active cycles", act_cyc - a0, 1, 6);

        // Good 0x55, then 0xAA whose stop bit turns into a 40-clock break.
        send_frame(8'h55, 1'b1, C);
        idle(2 * C);
        check("break pre byte", rx_byte, 8'h55);
        d0 = dv_cnt; e0 = err_cnt; r0 = act_rise;
        send_frame(8'hAA, 1'b0, 40);
        check("break active low", active,        1'b0);
        check("break err",        err_cnt - e0,  1);
        check("break dv",         dv_cnt - d0,   0);
        check("break starts",     act_rise - r0, 1);
        idle(3 * C);
        check("break no restart", act_rise - r0, 1);
        check("break byte held",  rx_byte,       8'h55);
        check("break err total",  err_cnt - e0,  1);

        // Back-to-back frames with no idle gap.
        d0 = dv_cnt; e0 = err_cnt;
        send_frame(8'h00, 1'b1, C);
        send_frame(8'hFF, 1'b1, C);
        idle(2 * C);
        check("b2b dv count", dv_cnt - d0,  2);
        check("b2b first",    prev_b,       8'h00);
        check("b2b second",   last_b,       8'hFF);
        check("b2b err",      err_cnt - e0, 0);

        // Reset in the middle of data bit 4 of 0x81; sender abandons the frame too.
        d0 = dv_cnt; e0 = err_cnt;
        drive_bit(1'b0, C);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i), C);
        drive_bit(1'b0, C / 2);
        check("midreset active before", active, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset active", active,  1'b0);
        check("midreset byte",   rx_byte, 8'h00);
        rst = 1'b0;
        idle(2 * C);
        check("midreset dv",  dv_cnt - d0,  0);
        check("midreset err", err_cnt - e0, 0);
        send_frame(8'h81, 1'b1, C);
        idle(2 * C);
        check("postreset dv",   dv_cnt - d0,  1);
        check("postreset byte", rx_byte,      8'h81);
        check("postreset err",  err_cnt - e0, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity accepted, then flipped parity rejected.
        d0 = dv_cnt; e0 = err_cnt;
        par_flip = 1'b0;
        send_frame(8'hA5, 1'b1, C);
        idle(2 * C);
        check("parity ok dv",   dv_cnt - d0,  1);
        check("parity ok byte", rx_byte,      8'hA5);
        d0 = dv_cnt; e0 = err_cnt;
        par_flip = 1'b1;
        send_frame(8'hA5, 1'b1, C);
        idle(2 * C);
        check("parity bad err",  err_cnt - e0, 1);
        check("parity bad dv",   dv_cnt - d0,  0);
        send_frame(8'h3C, 1'b1, C);
        idle(2 * C);
        check("parity bad2 err",  err_cnt - e0, 2);
        check("parity bad2 byte", rx_byte,      8'hA5);
        par_flip = 1'b0;
`endif

        check("dv+err same cycle", viol_both,   0);
        check("consecutive pulse", viol_consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
